mul_unit: RTL and testbench

MUL_UNIT -- requirements
Module: mul_unit

---
 rtl/mul_unit_pkg.sv | 30 +++
 rtl/mul_unit_step.sv | 25 ++
 rtl/mul_unit.sv | 123 ++++++++++++
 tb/tb_mul_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_unit_pkg.sv
// Shared RISC-V field defines plus the multiplier package.
// Holds the ALU opcode / funct encodings, the default word size and the
// multiplier FSM state type used by mul_unit.
`ifndef MUL_UNIT_DEFINES_SVH
`define MUL_UNIT_DEFINES_SVH
`define WORD_SIZE          32
`define OPCODE_ALU         7'b0110011
`define MUL_FUNCT7         7'b0000001
`define MUL_FUNCT3         3'b000
`define ADD_OR_AND_FUNCT7  7'b0000000
`define ADD_FUNCT3         3'b000
`endif

package mul_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    // True for the R-type MUL encoding (low-word product).
    function automatic logic is_mul_op(input logic [6:0] opcode,
                                       input logic [6:0] funct7,
                                       input logic [2:0] funct3);
        return (opcode == `OPCODE_ALU) && (funct7 == `MUL_FUNCT7) &&
               (funct3 == `MUL_FUNCT3);
    endfunction

endpackage

// File: rtl/mul_unit_step.sv
// One partial-product step: acc + mcand * slice, truncated to WORD_SIZE.
// Latency: combinational. Backpressure: none (pure datapath).
// Ports: acc_i running sum, mcand_i pre-shifted multiplicand, slice_i multiplier slice, acc_o new sum.
module mul_step #(
    parameter int WORD_SIZE = 32,
    parameter int SLICE_W   = 8
) (
    input  logic [WORD_SIZE-1:0] acc_i,
    input  logic [WORD_SIZE-1:0] mcand_i,
    input  logic [SLICE_W-1:0]   slice_i,
    output logic [WORD_SIZE-1:0] acc_o
);

    logic [WORD_SIZE-1:0] slice_ext;
    logic [WORD_SIZE-1:0] pp;

    always_comb begin
        slice_ext                = '0;
        slice_ext[SLICE_W-1:0]   = slice_i;
        // Only the low word is ever needed, so the product wraps freely.
        pp                       = mcand_i * slice_ext;
        acc_o                    = acc_i + pp;
    end

endmodule

// File: rtl/mul_unit.sv
// Iterative low-word multiplier in the execute stage; MUL_STEPS slice additions per op.
// Latency: result valid MUL_STEPS+1 edges after the MUL is presented (accept edge counted).
// Backpressure: stall holds D_E while accepting/busy, or while done and stall_in is high.
// Ports: clk/reset (async active-low); valid/opcode/funct7/funct3/pc/s1/s2 from D_E;
//        stall_in from E_M; flush kills the op; stall to D_E; result/pc_out/valid_out to E_M.
module mul_unit
    import mul_unit_pkg::*;
#(
    parameter int WORD_SIZE = `WORD_SIZE,
    parameter int MUL_STEPS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid,
    input  logic [6:0]           opcode,
    input  logic [6:0]           funct7,
    input  logic [2:0]           funct3,
    input  logic [WORD_SIZE-1:0] pc,
    input  logic [WORD_SIZE-1:0] s1,
    input  logic [WORD_SIZE-1:0] s2,
    input  logic                 stall_in,
    input  logic                 flush,
    output logic                 stall,
    output logic [WORD_SIZE-1:0] result,
    output logic [WORD_SIZE-1:0] pc_out,
    output logic                 valid_out
);

    localparam int SLICE_W = WORD_SIZE / MUL_STEPS;
    localparam int CNT_W   = $clog2(MUL_STEPS + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_STEPS - 1);

    mul_state_t           state_q;
    logic [WORD_SIZE-1:0] mcand_q;
    logic [WORD_SIZE-1:0] mplier_q;
    logic [WORD_SIZE-1:0] tag_q;
    logic [WORD_SIZE-1:0] acc_q;
    logic [WORD_SIZE-1:0] acc_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [WORD_SIZE-1:0] result_q;
    logic [WORD_SIZE-1:0] pc_out_q;
    logic                 valid_out_q;

    logic is_mul;
    logic accept;

    assign is_mul = valid & is_mul_op(opcode, funct7, funct3);
    assign accept = (state_q == ST_IDLE) & is_mul & ~flush;

    // Flush releases D_E immediately, even while busy or holding a result.
    assign stall = ~flush & (accept | (state_q == ST_BUSY) |
                             ((state_q == ST_DONE) & stall_in));

    // Multiplicand is shifted left and multiplier right each step, so the
    // step adder always consumes the low slice against an aligned operand.
    mul_step #(
        .WORD_SIZE (WORD_SIZE),
        .SLICE_W   (SLICE_W)
    ) u_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .slice_i (mplier_q[SLICE_W-1:0]),
        .acc_o   (acc_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            tag_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            pc_out_q    <= '0;
            valid_out_q <= 1'b0;
        end else if (flush) begin
            state_q     <= ST_IDLE;
            valid_out_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (is_mul) begin
                        mcand_q  <= s1;
                        mplier_q <= s2;
                        tag_q    <= pc;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << SLICE_W;
                    mplier_q <= mplier_q >> SLICE_W;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        // Capture outputs once so they stay stable outside DONE.
                        result_q    <= acc_d;
                        pc_out_q    <= tag_q;
                        valid_out_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!stall_in) begin
                        valid_out_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    valid_out_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign result    = result_q;
    assign pc_out    = pc_out_q;
    assign valid_out = valid_out_q;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit with a result/tag scoreboard.
// Latency: stimulus-driven. Backpressure: exercises stall_in hold and flush.
// Ports: drives every mul_unit port; clock period 10.
module tb_mul_unit;

    localparam logic [6:0] OPC_ALU  = 7'b0110011;
    localparam logic [6:0] F7_MUL   = 7'b0000001;
    localparam logic [6:0] F7_ADD   = 7'b0000000;
    localparam logic [2:0] F3_MUL   = 3'b000;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] pc;
    logic [31:0] s1;
    logic [31:0] s2;
    logic        stall_in;
    logic        flush;
    logic        stall;
    logic [31:0] result;
    logic [31:0] pc_out;
    logic        valid_out;

    typedef struct {
        logic [31:0] res;
        logic [31:0] tag;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   lat;

    mul_unit #(.WORD_SIZE(32), .MUL_STEPS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid     (valid),
        .opcode    (opcode),
        .funct7    (funct7),
        .funct3    (funct3),
        .pc        (pc),
        .s1        (s1),
        .s2        (s2),
        .stall_in  (stall_in),
        .flush     (flush),
        .stall     (stall),
        .result    (result),
        .pc_out    (pc_out),
        .valid_out (valid_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: pop on the cycle the result is handed off, verify hold otherwise.
    always @(negedge clk) begin
        #3;
        if (valid_out === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_vld", {63'd0, valid_out}, 64'd0);
            end else if (stall_in) begin
                chk("hold_res", {32'd0, result}, {32'd0, sb_q[0].res});
                chk("hold_pc", {32'd0, pc_out}, {32'd0, sb_q[0].tag});
            end else begin
                mon_e = sb_q.pop_front();
                chk("res", {32'd0, result}, {32'd0, mon_e.res});
                chk("pc", {32'd0, pc_out}, {32'd0, mon_e.tag});
            end
        end
    end

    task automatic issue_mul(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] p, input bit push);
        exp_t e;
        @(negedge clk);
        valid  = 1'b1;
        opcode = OPC_ALU;
        funct7 = F7_MUL;
        funct3 = F3_MUL;
        s1     = a;
        s2     = b;
        pc     = p;
        #1 chk("stall_acc", {63'd0, stall}, 64'd1);
        if (push) begin
            e.res = a * b;
            e.tag = p;
            sb_q.push_back(e);
        end
    endtask

    // Returns at negedge+1 of the first cycle with valid_out high.
    task automatic wait_done(output int n);
        bit done;
        done = 1'b0;
        n    = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) begin
                // D_E contents change after acceptance; the latched op must not.
                s1 = $urandom;
                s2 = $urandom;
                pc = $urandom;
            end
            #1;
            if (valid_out === 1'b1) done = 1'b1;
            else chk("stall_busy", {63'd0, stall}, 64'd1);
        end
        if (!done) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
        int n;
        issue_mul(a, b, p, 1'b1);
        wait_done(n);
        chk("latency", 64'(n), 64'd5);
        valid = 1'b0;
        #1 chk("stall_done", {63'd0, stall}, 64'd0);
    endtask

    initial begin
        reset    = 1'b0;
        valid    = 1'b0;
        opcode   = '0;
        funct7   = '0;
        funct3   = '0;
        pc       = '0;
        s1       = '0;
        s2       = '0;
        stall_in = 1'b0;
        flush    = 1'b0;
        #1;
        chk("rst_vld", {63'd0, valid_out}, 64'd0);
        chk("rst_res", {32'd0, result}, 64'd0);
        chk("rst_pc", {32'd0, pc_out}, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Non-MUL instruction is ignored.
        @(negedge clk);
        valid = 1'b1; opcode = OPC_ALU; funct7 = F7_ADD; funct3 = F3_MUL;
        s1 = 32'd3; s2 = 32'd4;
        #1 chk("add_stall", {63'd0, stall}, 64'd0);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("add_vld", {63'd0, valid_out}, 64'd0);
            chk("add_stall_q", {63'd0, stall}, 64'd0);
        end
        valid = 1'b0;

        // Directed products, back-to-back with a one-cycle gap.
        run_mul(32'd23, 32'd7, 32'h40);
        run_mul(32'hFFFF_FFFF, 32'd2, 32'h44);
        run_mul(32'h0001_0000, 32'h0001_0000, 32'h48);
        for (int i = 0; i < 4; i++) begin
            run_mul($urandom, $urandom, 32'h100 + 32'(i * 4));
        end
        @(negedge clk);
        #1 chk("idle_vld", {63'd0, valid_out}, 64'd0);

        // Downstream backpressure holds the result.
        issue_mul(32'h1234, 32'h5678, 32'h200, 1'b1);
        wait_done(lat);
        chk("latency_hold", 64'(lat), 64'd5);
        stall_in = 1'b1;
        #1 chk("stall_hold", {63'd0, stall}, 64'd1);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("vld_hold", {63'd0, valid_out}, 64'd1);
            chk("stall_hold_q", {63'd0, stall}, 64'd1);
        end
        stall_in = 1'b0;
        valid    = 1'b0;
        #1 chk("stall_release", {63'd0, stall}, 64'd0);
        @(negedge clk);
        #1 chk("vld_after_hold", {63'd0, valid_out}, 64'd0);

        // Flush in the second BUSY cycle kills the op.
        issue_mul(32'd5, 32'd6, 32'h300, 1'b0);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        valid = 1'b0;
        #1 chk("stall_flush", {63'd0, stall}, 64'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_stall_q", {63'd0, stall}, 64'd0);
        repeat (6) begin
            @(negedge clk);
            #1 chk("flush_vld", {63'd0, valid_out}, 64'd0);
        end
        run_mul(32'd212, 32'd73, 32'h304);

        // Flush beats a simultaneous accept.
        @(negedge clk);
        valid = 1'b1; opcode = OPC_ALU; funct7 = F7_MUL; funct3 = F3_MUL;
        s1 = 32'd9; s2 = 32'd9; pc = 32'h400;
        flush = 1'b1;
        #1 chk("flush_acc_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        flush = 1'b0;
        valid = 1'b0;
        #1 chk("flush_acc_idle", {63'd0, stall}, 64'd0);
        repeat (6) begin
            @(negedge clk);
            #1 chk("flush_acc_vld", {63'd0, valid_out}, 64'd0);
        end

        // Asynchronous reset mid-BUSY.
        issue_mul(32'd7, 32'd9, 32'h500, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #2;
        valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("arst_vld", {63'd0, valid_out}, 64'd0);
        chk("arst_res", {32'd0, result}, 64'd0);
        chk("arst_pc", {32'd0, pc_out}, 64'd0);
        chk("arst_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) begin
            @(negedge clk);
            #1 chk("post_rst_vld", {63'd0, valid_out}, 64'd0);
        end
        run_mul(32'd1000, 32'd1000, 32'h600);

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
